// File: rtl/bsk_prm_pkg.sv
// ---------------------------------------------------------------------------
// bsk_prm_pkg
// Shared types and constants for the PRM parallel-bus initiator.
//   state_e     : bus-cycle FSM states
//   ADDR_*      : PRM register addresses
//   ENABLE_KEY  : PRM enable key value
//   com_word()  : complement-checked command word encoder
// ---------------------------------------------------------------------------
package bsk_prm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_e;

    localparam logic [1:0] ADDR_COM_LO = 2'b00;
    localparam logic [1:0] ADDR_COM_HI = 2'b01;
    localparam logic [1:0] ADDR_IND    = 2'b10;
    localparam logic [1:0] ADDR_CTRL   = 2'b11;

    localparam logic [7:0] ENABLE_KEY  = 8'hE1;

    // The PRM checks each command byte against its complement in the upper half.
    function automatic logic [15:0] com_word(input logic [7:0] b);
        return {~b, b};
    endfunction

endpackage

// File: rtl/bsk_prm_master_if.sv
// ---------------------------------------------------------------------------
// bsk_prm_master_if
// Host request/response signals plus PRM bus-side signals of the initiator.
//   Host side : iReq, iWe, iAddr, iData, iComReq, iCom -> oRdy, oAck, oData
//   Bus side  : oCS, oA, oRd, oWr, oBusD, oBusDOe <- iBusD (from the pad)
// Modports:
//   master : view of the initiator block itself
//   slave  : view of the environment (host + pad) driving/observing it
// ---------------------------------------------------------------------------
interface bsk_prm_master_if;

    logic        iReq;
    logic        iWe;
    logic [1:0]  iAddr;
    logic [15:0] iData;
    logic        iComReq;
    logic [15:0] iCom;
    logic        oRdy;
    logic        oAck;
    logic [15:0] oData;
    logic [3:0]  oCS;
    logic [1:0]  oA;
    logic        oRd;
    logic        oWr;
    logic [15:0] oBusD;
    logic        oBusDOe;
    logic [15:0] iBusD;

    modport master (
        input  iReq, iWe, iAddr, iData, iComReq, iCom, iBusD,
        output oRdy, oAck, oData, oCS, oA, oRd, oWr, oBusD, oBusDOe
    );

    modport slave (
        output iReq, iWe, iAddr, iData, iComReq, iCom, iBusD,
        input  oRdy, oAck, oData, oCS, oA, oRd, oWr, oBusD, oBusDOe
    );

endinterface

// File: rtl/bsk_prm_bus_timer.sv
// ---------------------------------------------------------------------------
// bsk_prm_bus_timer
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
//   clk_i      : clock
//   res_n_i    : synchronous active-low reset
//   load_i     : load load_val_i (takes priority over counting)
//   load_val_i : phase length minus one
//   done_o     : counter has reached zero (last clock of the phase)
// ---------------------------------------------------------------------------
module bsk_prm_bus_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         res_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/bsk_prm_master.sv
// ---------------------------------------------------------------------------
// bsk_prm_master
// Host-side initiator for the PRM parallel bus. Turns single-cycle host
// requests into timed bus cycles (single read/write) and expands a 16-bit
// command into two complement-checked writes to the command registers.
// Ports:
//   iClk  : system clock
//   iRes  : synchronous active-low reset
//   bus   : bsk_prm_master_if.master (host request/response + bus pins)
// All outputs are registered.
// ---------------------------------------------------------------------------
module bsk_prm_master
    import bsk_prm_pkg::*;
#(
    parameter logic [3:0] CS       = 4'b0111,
    parameter int         T_SETUP  = 2,
    parameter int         T_STROBE = 4,
    parameter int         T_HOLD   = 2
) (
    input  logic               iClk,
    input  logic               iRes,
    bsk_prm_master_if.master   bus
);

    localparam int T_MAX1 = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int T_MAX  = (T_MAX1 > T_HOLD) ? T_MAX1 : T_HOLD;
    localparam int CNT_W  = $clog2(T_MAX + 1);

    state_e      state_q, state_d;
    logic        rdy_q, rdy_d;
    logic        ack_q, ack_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  cs_q, cs_d;
    logic [1:0]  a_q, a_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [15:0] busd_q, busd_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    // Set while command phase 0 runs: HOLD then chains into phase 1.
    logic        phase_q, phase_d;
    logic [7:0]  com_hi_q, com_hi_d;

    logic             tmr_done;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;

    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        ack_d    = 1'b0;
        data_d   = data_q;
        cs_d     = cs_q;
        a_d      = a_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        busd_d   = busd_q;
        oe_d     = oe_q;
        we_d     = we_q;
        phase_d  = phase_q;
        com_hi_d = com_hi_q;
        case (state_q)
            IDLE: begin
                // Command wins over a simultaneous single request.
                if (bus.iComReq) begin
                    state_d  = SETUP;
                    rdy_d    = 1'b0;
                    cs_d     = CS;
                    a_d      = ADDR_COM_LO;
                    busd_d   = com_word(bus.iCom[7:0]);
                    oe_d     = 1'b1;
                    we_d     = 1'b1;
                    phase_d  = 1'b1;
                    com_hi_d = bus.iCom[15:8];
                end else if (bus.iReq) begin
                    state_d = SETUP;
                    rdy_d   = 1'b0;
                    cs_d    = CS;
                    a_d     = bus.iAddr;
                    we_d    = bus.iWe;
                    phase_d = 1'b0;
                    if (bus.iWe) begin
                        busd_d = bus.iData;
                        oe_d   = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_d = STROBE;
                    if (we_q) wr_d = 1'b0;
                    else      rd_d = 1'b0;
                end
            end
            STROBE: begin
                if (tmr_done) begin
                    state_d = HOLD;
                    rd_d    = 1'b1;
                    wr_d    = 1'b1;
                    if (!we_q) data_d = bus.iBusD;
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    if (phase_q) begin
                        // Straight into phase 1 with CS still asserted.
                        state_d = SETUP;
                        phase_d = 1'b0;
                        a_d     = ADDR_COM_HI;
                        busd_d  = com_word(com_hi_q);
                    end else begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        cs_d    = ~CS;
                        oe_d    = 1'b0;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timer reloads with the new phase length on every state change.
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            SETUP:   tmr_val = CNT_W'(T_SETUP - 1);
            STROBE:  tmr_val = CNT_W'(T_STROBE - 1);
            HOLD:    tmr_val = CNT_W'(T_HOLD - 1);
            default: tmr_val = '0;
        endcase
    end

    bsk_prm_bus_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk_i      (iClk),
        .res_n_i    (iRes),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge iClk) begin
        if (!iRes) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b1;
            ack_q    <= 1'b0;
            data_q   <= '0;
            cs_q     <= ~CS;
            a_q      <= '0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            busd_q   <= '0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            phase_q  <= 1'b0;
            com_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            cs_q     <= cs_d;
            a_q      <= a_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            busd_q   <= busd_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            phase_q  <= phase_d;
            com_hi_q <= com_hi_d;
        end
    end

    assign bus.oRdy    = rdy_q;
    assign bus.oAck    = ack_q;
    assign bus.oData   = data_q;
    assign bus.oCS     = cs_q;
    assign bus.oA      = a_q;
    assign bus.oRd     = rd_q;
    assign bus.oWr     = wr_q;
    assign bus.oBusD   = busd_q;
    assign bus.oBusDOe = oe_q;

endmodule

// File: doc/bsk_prm_master.md
Name: bsk_prm_master

Overview:
- Synchronous host-side initiator for the asynchronous PRM parallel bus: the controller end that drives CS, address, Rd/Wr strobes and the 16-bit data bus into the PRM board.
- Turns single-cycle host requests into correctly timed bus cycles: single register read/write, plus a command-send operation that encodes a 16-bit command into the two complement-checked command-register writes the PRM expects.
- Sits between the controller core and the board-edge tristate pad; the pad (outside this block) combines oBusD/oBusDOe/iBusD into bD.

Parameters:
- CS, 4'b0111, chip-select code driven on oCS during a transaction; ~CS when idle.
- T_SETUP, 2, clocks CS/address/data are valid before the strobe falls (≥1).
- T_STROBE, 4, clocks oRd/oWr are held low (≥1).
- T_HOLD, 2, clocks CS/address/data are held after the strobe rises (≥1).

Ports:
- iClk  in  1  system clock.
- iRes  in  1  reset; synchronous, active-low.
- iReq  in  1  host single-transaction request pulse.
- iWe  in  1  1 = write, 0 = read; sampled with iReq.
- iAddr  in  2  register address; sampled with iReq.
- iData  in  16  write data; sampled with iReq.
- iComReq  in  1  command-send request pulse.
- iCom  in  16  command bits 16..1; sampled with iComReq.
- oRdy  out  1  1 = idle; requests are accepted only while oRdy=1.
- oAck  out  1  one-cycle completion pulse.
- oData  out  16  read data, valid from oAck onwards until the next read completes.
- oCS  out  4  bus chip select.
- oA  out  2  bus address.
- oRd  out  1  read strobe, active-low.
- oWr  out  1  write strobe, active-low.
- oBusD  out  16  bus write data.
- oBusDOe  out  1  1 = drive bD; only during write transactions.
- iBusD  in  16  bus read data from the pad.

Behaviour:
- All outputs are registered.
- Reset (iRes=0 at an edge) values:
  - state IDLE, oRdy=1, oAck=0, oData=0.
  - oCS=~CS, oA=0, oRd=1, oWr=1, oBusD=0, oBusDOe=0.
  - Reset applies mid-transaction too: strobes deassert and CS releases on that same edge, no oAck is issued, and a pending command second phase is discarded.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> (second phase ? SETUP : ACK) -> IDLE.
- Request acceptance (IDLE, iRes=1):
  - iComReq has priority over iReq; both high at once -> command accepted, iReq dropped.
  - Requests while oRdy=0 are ignored, not queued.
- Entering SETUP:
  - oRdy=0, oCS=CS, oA=address.
  - For writes: oBusD=data, oBusDOe=1.
- SETUP: T_SETUP clocks.
- STROBE: T_STROBE clocks; oRd=0 (read) or oWr=0 (write).
  - Reads capture iBusD into oData on the edge leaving STROBE.
- HOLD: T_HOLD clocks; strobes=1; oCS, oA, oBusD and oBusDOe unchanged.
- ACK: one clock; oAck=1, oCS=~CS, oBusDOe=0, oRd=oWr=1, oRdy=0. Next state IDLE (oRdy=1).
- Single-transaction latency:
  - Accept edge to oAck-high = T_SETUP+T_STROBE+T_HOLD+1 clocks (9 with defaults).
  - Next request is accepted one clock after oAck.
- Command encoding:
  - phase 0: write A=00, data {~iCom[7:0], iCom[7:0]}.
  - phase 1: write A=01, data {~iCom[15:8], iCom[15:8]}.
  - iCom is latched at accept.
  - Between phases, HOLD goes directly to SETUP of phase 1 with oCS kept active; no ACK between the phases.
  - A single oAck follows phase 1; total latency 2*(T_SETUP+T_STROBE+T_HOLD)+1.
- Cycle counter: a single down-counter of width $clog2(max(T_SETUP,T_STROBE,T_HOLD)+1), reloaded on every state entry.
- oRd and oWr are never low together; oBusDOe is never 1 while oRd=0.

Decomposition:
- Package bsk_prm_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, ACK);
  - register address constants (ADDR_COM_LO=2'b00, ADDR_COM_HI=2'b01, ADDR_IND=2'b10, ADDR_CTRL=2'b11);
  - the enable key constant 8'hE1;
  - an encode function com_word(byte) = {~byte, byte}.
- Optional sub-module bsk_prm_bus_timer: loadable down-counter with a done flag, reused for all three phases.

Test Plan:
- Write A=10, data 16'h1234 (default timing):
  - oCS=0111 for 8 clocks; oWr low on clocks 3–6 after accept.
  - oBusD=16'h1234 with oBusDOe=1 throughout; oAck at clock 9; oRd stays 1.
- Read A=11 with iBusD=16'hA693:
  - oRd low 4 clocks, oBusDOe=0.
  - oData=16'hA693 when oAck=1 and after it.
- Command iCom=16'h5AF0:
  - Write A=00 with 16'h0FF0, then A=01 with 16'hA55A; oCS continuously active.
  - Exactly one oAck, at clock 17.
- Simultaneous iReq (read A=11) and iComReq: only the command is performed. iReq pulses during busy are ignored (no extra bus cycles, one oAck).
- iRes=0 during STROBE of command phase 0:
  - Next edge: oWr=1, oCS=1000, oBusDOe=0, oRdy=1, no oAck, no phase 1.
  - A fresh write afterwards completes normally.
- Parameter sweep T_SETUP/T_STROBE/T_HOLD=1/1/1:
  - Single write gives oAck on clock 4.
  - Back-to-back requests issued the clock after each oAck produce contiguous correct bus cycles.
